instruction_fetch: RTL and testbench
====================================

// Module: instruction_fetch
// PURPOSE
//  Program counter and fetch stage directly upstream of the instruction decoder.
//  - Issues addresses to a synchronous-read program memory.
//  - Registers each returned word onto Ins, which drives the decoder, with a valid/stall handshake.
//  - Absorbs downstream stalls with a 1-entry skid buffer; flushes and redirects on jumps.
// PARAMETERS
//  INS_W    13     instruction width; equals `ID_IN_MSB+1
//  ADDR_W   8      program address width
//  RST_ADDR 0      first fetch address after Start
// PORTS
//  clk       in   1       clock; all state updates on rising edge
//  rst_n     in   1       reset, synchronous, active-low
//  Start     in   1       begin fetching at RST_ADDR (honoured only in IDLE)
//  Halt      in   1       stop fetching, return to IDLE
//  Stall     in   1       decoder not accepting; Ins/Ins_Valid/Ins_PC hold
//  Jmp       in   1       redirect fetch to JmpAddr (honoured only in RUN)
//  JmpAddr   in   ADDR_W  jump target
//  PM_Addr   out  ADDR_W  program memory address (= FetchPC, combinational)
//  PM_RE     out  1       read enable; =1 iff state==RUN && !Stall && !Jmp && !Halt
//  PM_Data   in   INS_W   mem[PM_Addr], valid the cycle after a PM_RE=1 cycle
//  Ins       out  INS_W   instruction to decoder (registered)
//  Ins_Valid out  1       Ins holds a live instruction
//  Ins_PC    out  ADDR_W  address Ins was fetched from
//  Busy      out  1       state==RUN
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): IDLE; FetchPC=RST_ADDR; Ins=0; Ins_Valid=0; Ins_PC=0; skid empty;
//    in-flight flag cleared. PM_RE=0 and Busy=0 follow from IDLE. Reset overrides all inputs.
//  - States: IDLE -(Start && !Halt)-> RUN; RUN -(Halt)-> IDLE.
//    Start in RUN is ignored. Entering RUN loads FetchPC=RST_ADDR.
//  - Issue: a PM_RE=1 cycle sets InFlight and InFlightPC=FetchPC for the next cycle,
//    and FetchPC+=1 modulo 2^ADDR_W (0xFF wraps to 0x00).
//  - Capture at each edge in RUN with !Jmp && !Halt:
//    - Stall=0: skid full -> Ins<=Skid, empty skid; else InFlight -> Ins<=PM_Data;
//      else Ins_Valid<=0 (Ins holds). Ins_PC tracks the captured word; Ins_Valid<=1 on a load.
//    - Stall=1: Ins, Ins_Valid and Ins_PC hold; InFlight data -> skid (never overflows,
//      since no issue occurs while stalled).
//  - Latency: Start edge E -> PM_RE=1 in cycle after E -> Ins_Valid=1 with mem[RST_ADDR]
//    after edge E+2. Steady state is 1 instruction per cycle.
//  - Jmp edge (RUN): FetchPC<=JmpAddr; Ins_Valid<=0; skid and InFlight discarded.
//    Jmp has priority over Stall. Target instruction is valid 2 edges later; Ins_Valid is
//    low for 2 cycles.
//  - Halt edge (RUN): IDLE; Ins_Valid<=0; skid and InFlight discarded.
//    Halt beats Jmp and Start at the same edge.
//  - No instruction is ever duplicated or skipped across a stall; squashed words never reach Ins.
// TESTING
//  1 mem[a]=0x100+a; reset 2 cyc; Start pulse -> PM_Addr 0,1,2..;
//    Ins_Valid after 2 edges: Ins=0x100/PC 0, then 0x101, 0x102 each cycle.
//  2 Stall=1 for 3 cyc while Ins=0x105 -> Ins holds 0x105, PM_RE=0, skid takes 0x106;
//    release -> 0x106, 0x107 back-to-back.
//  3 Jmp, JmpAddr=0x40 while Ins=0x10A -> Ins_Valid 0 for 2 cyc, 0x10B never seen,
//    then Ins=0x140/PC 0x40.
//  4 Jmp to 0xFE -> Ins_PC 0xFE, 0xFF, 0x00, 0x01; PM_Addr wraps likewise.
//  5 Jmp with Stall=1 and skid full -> skid discarded, fetch resumes at target;
//    Halt+Jmp same edge -> IDLE, Busy=0.
//  6 rst_n=0 one cycle mid-RUN with PM_Data pending -> Ins_Valid=0, Ins=0, no capture;
//    Start restarts at RST_ADDR.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: control inputs, program-memory port and decoder-facing outputs.
interface instruction_fetch_if #(
  parameter int unsigned INS_W  = 13,
  parameter int unsigned ADDR_W = 8
);

  // Control from the sequencer / decoder
  logic              Start;
  logic              Halt;
  logic              Stall;
  logic              Jmp;
  logic [ADDR_W-1:0] JmpAddr;

  // Synchronous-read program memory port
  logic [ADDR_W-1:0] PM_Addr;
  logic              PM_RE;
  logic [INS_W-1:0]  PM_Data;

  // Instruction handed to the decoder
  logic [INS_W-1:0]  Ins;
  logic              Ins_Valid;
  logic [ADDR_W-1:0] Ins_PC;
  logic              Busy;

  // Fetch unit side
  modport master (
    input  Start, Halt, Stall, Jmp, JmpAddr, PM_Data,
    output PM_Addr, PM_RE, Ins, Ins_Valid, Ins_PC, Busy
  );

  // Environment side (sequencer, memory, decoder)
  modport slave (
    output Start, Halt, Stall, Jmp, JmpAddr, PM_Data,
    input  PM_Addr, PM_RE, Ins, Ins_Valid, Ins_PC, Busy
  );

endinterface

// File: rtl/instruction_fetch.sv
// Program counter and fetch stage feeding the instruction decoder.
// Issues reads to a synchronous program memory, registers returned words onto
// Ins with a valid/stall handshake, absorbs one stalled word in a skid buffer
// and squashes in-flight work on jumps and halts.
module instruction_fetch #(
  parameter int unsigned       INS_W    = 13,
  parameter int unsigned       ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RST_ADDR = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  instruction_fetch_if.master  bus
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e            state_q,        state_d;
  logic [ADDR_W-1:0] fetch_pc_q,     fetch_pc_d;
  logic              in_flight_q,    in_flight_d;
  logic [ADDR_W-1:0] in_flight_pc_q, in_flight_pc_d;
  logic              skid_valid_q,   skid_valid_d;
  logic [INS_W-1:0]  skid_q,         skid_d;
  logic [ADDR_W-1:0] skid_pc_q,      skid_pc_d;
  logic [INS_W-1:0]  ins_q,          ins_d;
  logic              ins_valid_q,    ins_valid_d;
  logic [ADDR_W-1:0] ins_pc_q,       ins_pc_d;
  logic              pm_re_c;

  // A read is issued only on a clean RUN cycle; jumps and halts suppress it
  assign pm_re_c = (state_q == ST_RUN) && !bus.Stall && !bus.Jmp && !bus.Halt;

  assign bus.PM_Addr   = fetch_pc_q;
  assign bus.PM_RE     = pm_re_c;
  assign bus.Ins       = ins_q;
  assign bus.Ins_Valid = ins_valid_q;
  assign bus.Ins_PC    = ins_pc_q;
  assign bus.Busy      = (state_q == ST_RUN);

  // Next-state, issue and capture logic
  always_comb begin
    state_d        = state_q;
    fetch_pc_d     = fetch_pc_q;
    in_flight_d    = 1'b0;
    in_flight_pc_d = in_flight_pc_q;
    skid_valid_d   = skid_valid_q;
    skid_d         = skid_q;
    skid_pc_d      = skid_pc_q;
    ins_d          = ins_q;
    ins_valid_d    = ins_valid_q;
    ins_pc_d       = ins_pc_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.Start && !bus.Halt) begin
          state_d    = ST_RUN;
          fetch_pc_d = RST_ADDR;
        end
      end

      ST_RUN: begin
        if (bus.Halt) begin
          // Halt wins over Jmp and Start; all pending work is dropped
          state_d      = ST_IDLE;
          ins_valid_d  = 1'b0;
          skid_valid_d = 1'b0;
        end else if (bus.Jmp) begin
          // Redirect; the word on Ins, the skid and the in-flight read are squashed
          fetch_pc_d   = bus.JmpAddr;
          ins_valid_d  = 1'b0;
          skid_valid_d = 1'b0;
        end else begin
          if (pm_re_c) begin
            in_flight_d    = 1'b1;
            in_flight_pc_d = fetch_pc_q;
            fetch_pc_d     = fetch_pc_q + ADDR_W'(1);
          end

          if (!bus.Stall) begin
            // Skid is older than any in-flight word, so it drains first
            if (skid_valid_q) begin
              ins_d        = skid_q;
              ins_pc_d     = skid_pc_q;
              ins_valid_d  = 1'b1;
              skid_valid_d = 1'b0;
            end else if (in_flight_q) begin
              ins_d       = bus.PM_Data;
              ins_pc_d    = in_flight_pc_q;
              ins_valid_d = 1'b1;
            end else begin
              ins_valid_d = 1'b0;
            end
          end else if (in_flight_q) begin
            // Decoder is holding Ins; park the returning word
            skid_d       = bus.PM_Data;
            skid_pc_d    = in_flight_pc_q;
            skid_valid_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      fetch_pc_q     <= RST_ADDR;
      in_flight_q    <= 1'b0;
      in_flight_pc_q <= '0;
      skid_valid_q   <= 1'b0;
      skid_q         <= '0;
      skid_pc_q      <= '0;
      ins_q          <= '0;
      ins_valid_q    <= 1'b0;
      ins_pc_q       <= '0;
    end else begin
      state_q        <= state_d;
      fetch_pc_q     <= fetch_pc_d;
      in_flight_q    <= in_flight_d;
      in_flight_pc_q <= in_flight_pc_d;
      skid_valid_q   <= skid_valid_d;
      skid_q         <= skid_d;
      skid_pc_q      <= skid_pc_d;
      ins_q          <= ins_d;
      ins_valid_q    <= ins_valid_d;
      ins_pc_q       <= ins_pc_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios followed by a randomized run
// checked against an in-order instruction-stream reference model.
module tb_instruction_fetch;

  localparam int unsigned INS_W  = 13;
  localparam int unsigned ADDR_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  int               total = 0;
  int               bad   = 0;
  logic [INS_W-1:0] mem [256];
  logic [INS_W-1:0] pm_data_q = '0;

  instruction_fetch_if #(.INS_W(INS_W), .ADDR_W(ADDR_W)) bus ();

  instruction_fetch #(
    .INS_W   (INS_W),
    .ADDR_W  (ADDR_W),
    .RST_ADDR(8'h00)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Synchronous-read program memory
  always @(posedge clk) begin
    if (bus.PM_RE) pm_data_q <= mem[bus.PM_Addr];
  end
  assign bus.PM_Data = pm_data_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic expect_ins(input string tag, input logic v, input logic [INS_W-1:0] ins,
                            input logic [ADDR_W-1:0] pc);
    check({tag, "_valid"}, 32'(bus.Ins_Valid), 32'(v));
    if (v) begin
      check({tag, "_ins"}, 32'(bus.Ins), 32'(ins));
      check({tag, "_pc"},  32'(bus.Ins_PC), 32'(pc));
    end
  endtask

  initial begin
    logic              running;
    logic [ADDR_W-1:0] exp_pc;
    int                delivered;
    logic              hold_pending;
    logic [INS_W-1:0]  held_ins;
    logic [ADDR_W-1:0] held_pc;

    for (int a = 0; a < 256; a++) mem[a] = INS_W'(32'h100 + a);
    rst_n = 1'b0;
    bus.Start = 1'b0; bus.Halt = 1'b0; bus.Stall = 1'b0; bus.Jmp = 1'b0; bus.JmpAddr = '0;

    // Reset for two cycles
    step(); step();
    rst_n = 1'b1;
    settle();
    check("rst_valid", 32'(bus.Ins_Valid), 32'd0);
    check("rst_ins",   32'(bus.Ins), 32'd0);
    check("rst_pc",    32'(bus.Ins_PC), 32'd0);
    check("rst_busy",  32'(bus.Busy), 32'd0);
    check("rst_re",    32'(bus.PM_RE), 32'd0);

    // 1: start and stream sequentially
    bus.Start = 1'b1;
    settle();
    check("t1_idle_re", 32'(bus.PM_RE), 32'd0);
    step();
    bus.Start = 1'b0;
    settle();
    check("t1_busy", 32'(bus.Busy), 32'd1);
    check("t1_re",   32'(bus.PM_RE), 32'd1);
    check("t1_addr0", 32'(bus.PM_Addr), 32'h00);
    expect_ins("t1_lat0", 1'b0, '0, '0);
    step(); settle();
    check("t1_addr1", 32'(bus.PM_Addr), 32'h01);
    expect_ins("t1_lat1", 1'b0, '0, '0);
    step(); settle();
    expect_ins("t1_first", 1'b1, 13'h100, 8'h00);
    check("t1_addr2", 32'(bus.PM_Addr), 32'h02);
    for (int k = 1; k <= 5; k++) begin
      bus.Start = (k == 3);
      step();
      bus.Start = 1'b0;
      settle();
      expect_ins("t1_seq", 1'b1, INS_W'(32'h100 + k), ADDR_W'(k));
      check("t1_seq_addr", 32'(bus.PM_Addr), 32'(k + 2));
    end

    // 2: stall three cycles while Ins=0x105
    for (int i = 0; i < 3; i++) begin
      bus.Stall = 1'b1;
      settle();
      expect_ins("t2_hold", 1'b1, 13'h105, 8'h05);
      check("t2_re_stall", 32'(bus.PM_RE), 32'd0);
      step();
    end
    bus.Stall = 1'b0;
    settle();
    expect_ins("t2_release", 1'b1, 13'h105, 8'h05);
    check("t2_re_release", 32'(bus.PM_RE), 32'd1);
    for (int k = 6; k <= 10; k++) begin
      step(); settle();
      expect_ins("t2_after", 1'b1, INS_W'(32'h100 + k), ADDR_W'(k));
    end

    // 3: jump to 0x40 while Ins=0x10A
    bus.Jmp = 1'b1; bus.JmpAddr = 8'h40;
    settle();
    check("t3_re_jmp", 32'(bus.PM_RE), 32'd0);
    step();
    bus.Jmp = 1'b0;
    settle();
    expect_ins("t3_bub0", 1'b0, '0, '0);
    check("t3_addr", 32'(bus.PM_Addr), 32'h40);
    check("t3_re",   32'(bus.PM_RE), 32'd1);
    step(); settle();
    expect_ins("t3_bub1", 1'b0, '0, '0);
    step(); settle();
    expect_ins("t3_tgt", 1'b1, 13'h140, 8'h40);
    step(); settle();
    expect_ins("t3_tgt1", 1'b1, 13'h141, 8'h41);

    // 4: jump to 0xFE and wrap
    bus.Jmp = 1'b1; bus.JmpAddr = 8'hFE;
    step();
    bus.Jmp = 1'b0;
    settle();
    check("t4_addr_fe", 32'(bus.PM_Addr), 32'hFE);
    step(); settle();
    check("t4_addr_ff", 32'(bus.PM_Addr), 32'hFF);
    step(); settle();
    check("t4_addr_00", 32'(bus.PM_Addr), 32'h00);
    expect_ins("t4_fe", 1'b1, 13'h1FE, 8'hFE);
    step(); settle();
    expect_ins("t4_ff", 1'b1, 13'h1FF, 8'hFF);
    step(); settle();
    expect_ins("t4_00", 1'b1, 13'h100, 8'h00);
    step(); settle();
    expect_ins("t4_01", 1'b1, 13'h101, 8'h01);

    // 5: fill skid, then jump while stalled
    bus.Stall = 1'b1;
    step();
    bus.Jmp = 1'b1; bus.JmpAddr = 8'h80;
    settle();
    expect_ins("t5_hold", 1'b1, 13'h101, 8'h01);
    check("t5_re", 32'(bus.PM_RE), 32'd0);
    step();
    bus.Jmp = 1'b0; bus.Stall = 1'b0;
    settle();
    expect_ins("t5_bub0", 1'b0, '0, '0);
    check("t5_addr", 32'(bus.PM_Addr), 32'h80);
    step(); settle();
    expect_ins("t5_bub1", 1'b0, '0, '0);
    step(); settle();
    expect_ins("t5_tgt", 1'b1, 13'h180, 8'h80);
    // Halt and Jmp at the same edge
    bus.Halt = 1'b1; bus.Jmp = 1'b1; bus.JmpAddr = 8'h20;
    settle();
    check("t5_halt_re", 32'(bus.PM_RE), 32'd0);
    step();
    bus.Halt = 1'b0; bus.Jmp = 1'b0;
    settle();
    check("t5_halt_busy", 32'(bus.Busy), 32'd0);
    check("t5_halt_re2", 32'(bus.PM_RE), 32'd0);
    expect_ins("t5_halt", 1'b0, '0, '0);
    // Start together with Halt stays idle
    bus.Start = 1'b1; bus.Halt = 1'b1;
    step();
    bus.Halt = 1'b0; bus.Start = 1'b0;
    settle();
    check("t5_starthalt_busy", 32'(bus.Busy), 32'd0);

    // 6: reset mid-run with a read pending
    bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    step(); step();
    settle();
    expect_ins("t6_run", 1'b1, 13'h100, 8'h00);
    check("t6_pending_re", 32'(bus.PM_RE), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    settle();
    check("t6_rst_valid", 32'(bus.Ins_Valid), 32'd0);
    check("t6_rst_ins",   32'(bus.Ins), 32'd0);
    check("t6_rst_busy",  32'(bus.Busy), 32'd0);
    step(); settle();
    check("t6_nocapture_valid", 32'(bus.Ins_Valid), 32'd0);
    check("t6_nocapture_ins",   32'(bus.Ins), 32'd0);
    bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    settle();
    check("t6_restart_addr", 32'(bus.PM_Addr), 32'h00);
    step(); step(); settle();
    expect_ins("t6_restart", 1'b1, 13'h100, 8'h00);

    // Randomized run against the stream model
    bus.Halt = 1'b1;
    step();
    bus.Halt = 1'b0;
    for (int a = 0; a < 256; a++) mem[a] = INS_W'($urandom);
    running      = 1'b0;
    exp_pc       = '0;
    delivered    = 0;
    hold_pending = 1'b0;
    held_ins     = '0;
    held_pc      = '0;
    for (int c = 0; c < 3000; c++) begin
      bus.Start   = 1'($urandom_range(0, 1));
      bus.Halt    = ($urandom_range(0, 99) < 2);
      bus.Stall   = ($urandom_range(0, 99) < 30);
      bus.Jmp     = ($urandom_range(0, 99) < 6);
      bus.JmpAddr = ADDR_W'($urandom);
      settle();
      check("r_busy", 32'(bus.Busy), 32'(running));
      check("r_re", 32'(bus.PM_RE), 32'(running && !bus.Stall && !bus.Jmp && !bus.Halt));
      if (hold_pending) begin
        check("r_hold_valid", 32'(bus.Ins_Valid), 32'd1);
        check("r_hold_ins", 32'(bus.Ins), 32'(held_ins));
        check("r_hold_pc", 32'(bus.Ins_PC), 32'(held_pc));
      end
      if (!running) begin
        check("r_idle_valid", 32'(bus.Ins_Valid), 32'd0);
      end else if (bus.Ins_Valid && !bus.Stall) begin
        check("r_stream_pc", 32'(bus.Ins_PC), 32'(exp_pc));
        check("r_stream_ins", 32'(bus.Ins), 32'(mem[exp_pc]));
        exp_pc++;
        delivered++;
      end
      hold_pending = running && bus.Ins_Valid && bus.Stall && !bus.Jmp && !bus.Halt;
      held_ins     = bus.Ins;
      held_pc      = bus.Ins_PC;
      if (!running) begin
        if (bus.Start && !bus.Halt) begin
          running = 1'b1;
          exp_pc  = 8'h00;
        end
      end else if (bus.Halt) begin
        running = 1'b0;
      end else if (bus.Jmp) begin
        exp_pc = bus.JmpAddr;
      end
      step();
    end
    check("r_delivered_enough", 32'(delivered > 300), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
